// File: rtl/stdp_synapse_bank.sv
// ---------------------------------------------------------------------------
// stdp_synapse_bank
//
// Spike-timing-dependent plasticity engine for one postsynaptic neuron fed by
// CHANNELS presynaptic inputs. Each accepted `apply` advances one timestep,
// ages every spike counter (saturating), and latches which channels need a
// potentiation (LTP) or depression (LTD) update. The engine then spends
// exactly CHANNELS cycles sweeping the channels through one shared multiplier.
//
// Handshake: `apply` is a request qualified by `ready`. A step is taken only on
// an edge where ready=1 and load=0. There is no buffering: apply, spike flags
// and load presented while ready=0 are discarded. `update_done` pulses for one
// cycle when a sweep finishes; ready is already high in that same cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   apply        advance one timestep (taken when ready=1)
//   pre_spike    per-channel presynaptic spike flags, sampled on accepted apply
//   post_spike   postsynaptic spike flag, sampled on accepted apply
//   load         write weight_init into every weight (IDLE only, beats apply)
//   weight_init  weight value used by load
//   m1, b1       LTP slope / intercept (signed Q-format)
//   m2, b2       LTD slope / intercept (signed Q-format)
//   w_min, w_max weight clamp bounds
//   weights      packed weights, channel k at [k*N +: N]
//   timestep     accepted-apply counter, wraps modulo 2^TW
//   ready        high in IDLE
//   update_done  one-cycle pulse at the end of each sweep
//   state_dbg    current FSM state (0 = IDLE, 1 = UPDATE)
// ---------------------------------------------------------------------------
module stdp_synapse_bank #(
   parameter int N        = 32,
   parameter int Q        = 16,
   parameter int CHANNELS = 4,
   parameter int TW       = 16,
   parameter int WINDOW   = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  apply,
   input  logic [CHANNELS-1:0]   pre_spike,
   input  logic                  post_spike,
   input  logic                  load,
   input  logic [N-1:0]          weight_init,
   input  logic [N-1:0]          m1,
   input  logic [N-1:0]          b1,
   input  logic [N-1:0]          m2,
   input  logic [N-1:0]          b2,
   input  logic [N-1:0]          w_min,
   input  logic [N-1:0]          w_max,
   output logic [CHANNELS*N-1:0] weights,
   output logic [TW-1:0]         timestep,
   output logic                  ready,
   output logic                  update_done,
   output logic                  state_dbg
);

   // Elaboration-time sanity checks on the parameter set.
   if (Q >= N) begin : g_bad_q
      $error("stdp_synapse_bank: Q must be smaller than N");
   end
   if (CHANNELS < 1) begin : g_bad_channels
      $error("stdp_synapse_bank: CHANNELS must be at least 1");
   end
   if (WINDOW >= (2 ** TW) - 1) begin : g_bad_window
      $error("stdp_synapse_bank: WINDOW must be below the saturated age");
   end

   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [TW-1:0] AGE_MAX  = '1;
   localparam logic [TW-1:0] WIN      = TW'(WINDOW);
   localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      UPDATE = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [IW-1:0]       idx;
   logic [N-1:0]        w_q      [CHANNELS];
   logic [TW-1:0]       pre_age  [CHANNELS];
   logic [TW-1:0]       post_age;
   logic [CHANNELS-1:0] ltp_mask;
   logic [CHANNELS-1:0] ltd_mask;

   // Values the ages/masks take on an accepted apply.
   logic [TW-1:0]       pre_age_nxt [CHANNELS];
   logic [TW-1:0]       post_age_nxt;
   logic [CHANNELS-1:0] ltp_nxt;
   logic [CHANNELS-1:0] ltd_nxt;

   logic accept;
   logic do_load;
   logic last;

   assign accept    = (state == IDLE) && apply && !load;
   assign do_load   = (state == IDLE) && load;
   assign last      = (idx == LAST_IDX);
   assign ready     = (state == IDLE);
   assign state_dbg = logic'(state);

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = UPDATE;
         UPDATE:  if (last)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Spike ages and plasticity masks for the next step.
   // Ages saturate at all-ones, which doubles as "no spike seen yet".
   // A spiking channel's age restarts at 0 after the increment, so a pre and
   // post spike in the same step give LTP with dt=0 and suppress LTD.
   // ------------------------------------------------------------------------
   always_comb begin
      post_age_nxt = post_spike ? '0
                   : ((post_age == AGE_MAX) ? AGE_MAX : post_age + TW'(1));
      for (int k = 0; k < CHANNELS; k++) begin
         pre_age_nxt[k] = pre_spike[k] ? '0
                        : ((pre_age[k] == AGE_MAX) ? AGE_MAX : pre_age[k] + TW'(1));
         ltp_nxt[k] = post_spike && (pre_age_nxt[k] <= WIN);
         ltd_nxt[k] = pre_spike[k] && !post_spike && (post_age_nxt <= WIN);
      end
   end

   // ------------------------------------------------------------------------
   // Shared update datapath for channel idx.
   // ------------------------------------------------------------------------
   logic                   sel_ltp;
   logic                   sel_ltd;
   logic [TW-1:0]          dt;
   logic signed [N-1:0]    m_sel;
   logic signed [N-1:0]    b_sel;
   logic signed [N+TW-1:0] prod;
   logic signed [N-1:0]    prod_sat;
   logic signed [N:0]      mag_raw;
   logic [N-1:0]           mag_pos;
   logic signed [N:0]      w_ext;
   logic signed [N:0]      w_sum;
   logic signed [N:0]      w_lo;
   logic signed [N:0]      w_hi;
   logic signed [N:0]      w_floor;
   logic [N-1:0]           w_new;

   always_comb begin
      sel_ltp = ltp_mask[idx];
      sel_ltd = ltd_mask[idx];
      dt      = sel_ltp ? pre_age[idx] : post_age;
      m_sel   = sel_ltp ? $signed(m1) : $signed(m2);
      b_sel   = sel_ltp ? $signed(b1) : $signed(b2);

      // dt is a plain step count: no fractional shift after the multiply.
      prod = (N+TW)'(m_sel) * (N+TW)'($signed({1'b0, dt}));

      // Saturate the product back to N bits when its top bits disagree.
      if ((&prod[N+TW-1:N-1]) || !(|prod[N+TW-1:N-1])) begin
         prod_sat = prod[N-1:0];
      end else if (prod[N+TW-1]) begin
         prod_sat = {1'b1, {(N-1){1'b0}}};
      end else begin
         prod_sat = {1'b0, {(N-1){1'b1}}};
      end

      // Negative magnitudes mean "outside the useful part of the curve".
      mag_raw = {b_sel[N-1], b_sel} - {prod_sat[N-1], prod_sat};
      if (mag_raw[N]) begin
         mag_pos = '0;
      end else if (mag_raw[N-1]) begin
         mag_pos = {1'b0, {(N-1){1'b1}}};
      end else begin
         mag_pos = mag_raw[N-1:0];
      end

      w_ext = {w_q[idx][N-1], w_q[idx]};
      w_sum = sel_ltp ? (w_ext + $signed({1'b0, mag_pos}))
                      : (w_ext - $signed({1'b0, mag_pos}));

      w_lo    = {w_min[N-1], w_min};
      w_hi    = {w_max[N-1], w_max};
      w_floor = (w_sum < w_lo) ? w_lo : w_sum;
      w_new   = (w_floor > w_hi) ? w_max : w_floor[N-1:0];
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx         <= '0;
         timestep    <= '0;
         post_age    <= AGE_MAX;
         ltp_mask    <= '0;
         ltd_mask    <= '0;
         update_done <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            w_q[k]     <= '0;
            pre_age[k] <= AGE_MAX;
         end
      end else begin
         update_done <= 1'b0;
         case (state)
            IDLE: begin
               if (do_load) begin
                  for (int k = 0; k < CHANNELS; k++) begin
                     w_q[k] <= weight_init;
                  end
               end else if (accept) begin
                  timestep <= timestep + TW'(1);
                  post_age <= post_age_nxt;
                  for (int k = 0; k < CHANNELS; k++) begin
                     pre_age[k] <= pre_age_nxt[k];
                  end
                  ltp_mask <= ltp_nxt;
                  ltd_mask <= ltd_nxt;
                  idx      <= '0;
               end
            end
            UPDATE: begin
               // Channels with no mask bit still take their cycle.
               if (sel_ltp || sel_ltd) begin
                  w_q[idx] <= w_new;
               end
               if (last) begin
                  idx         <= '0;
                  update_done <= 1'b1;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign weights[g*N +: N] = w_q[g];
   end

endmodule
